div: RTL and testbench



---
 rtl/div.sv | 140 ++++++++++++++
 tb/tb_div.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; stalls the pipeline while busy and honours annul.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  // state    | meaning
  // IDLE     | waiting for an accepted start_i
  // DIV_ZERO | divisor was zero; result is fixed, one cycle
  // DIV_ON   | 32 shift/trial-subtract iterations, cnt 0..31
  // DIV_END  | result_o valid, ready_o strobe
  typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [32:0] r;
  logic [31:0] q;
  logic [31:0] dsr;
  logic [1:0]  op_r;
  logic        sign_a, sign_b;

  logic        signed_mode;
  logic        accept;
  logic        dsr_zero;
  logic [31:0] abs_a, abs_b;

  assign signed_mode = ~op_i[0];
  assign accept      = (state == IDLE) & start_i & ~annul_i;
  assign dsr_zero    = (opdata2_i == 32'd0);
  assign abs_a       = (signed_mode & opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_b       = (signed_mode & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  logic [33:0] trial;
  logic [32:0] r_step;
  logic [31:0] q_step;
  logic [31:0] q_fix, r_fix;
  logic [31:0] div_res, zero_res;
  logic        neg_q, neg_r;

  always_comb begin
    trial = {r, q[31]} - {2'b00, dsr};
    if (!trial[33]) begin
      r_step = trial[32:0];
      q_step = {q[30:0], 1'b1};
    end else begin
      r_step = {r[31:0], q[31]};
      q_step = {q[30:0], 1'b0};
    end
  end

  // Sign fix-up is applied to the final iteration's values, not the registers.
  assign neg_q    = ~op_r[0] & (sign_a ^ sign_b);
  assign neg_r    = ~op_r[0] & sign_a;
  assign q_fix    = neg_q ? (~q_step + 32'd1) : q_step;
  assign r_fix    = neg_r ? (~r_step[31:0] + 32'd1) : r_step[31:0];
  assign div_res  = op_r[1] ? r_fix : q_fix;
  // In the divide-by-zero path q holds the raw dividend.
  assign zero_res = op_r[1] ? q : 32'hFFFF_FFFF;

  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    case (state)
      IDLE: begin
        stallreq_o = start_i & ~annul_i;
        if (accept) state_nxt = dsr_zero ? DIV_ZERO : DIV_ON;
      end
      DIV_ZERO: begin
        stallreq_o = 1'b1;
        state_nxt  = annul_i ? IDLE : DIV_END;
      end
      DIV_ON: begin
        stallreq_o = ~annul_i;
        if (annul_i)             state_nxt = IDLE;
        else if (cnt == 5'd31)   state_nxt = DIV_END;
      end
      DIV_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 5'd0;
      r        <= 33'd0;
      q        <= 32'd0;
      dsr      <= 32'd0;
      op_r     <= 2'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result_o <= 32'd0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= (state_nxt == DIV_END);
      case (state)
        IDLE: begin
          if (accept) begin
            op_r   <= op_i;
            sign_a <= signed_mode & opdata1_i[31];
            sign_b <= signed_mode & opdata2_i[31];
            dsr    <= abs_b;
            cnt    <= 5'd0;
            r      <= 33'd0;
            q      <= dsr_zero ? opdata1_i : abs_a;
          end
        end
        DIV_ON: begin
          if (!annul_i) begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) result_o <= div_res;
          end
        end
        DIV_ZERO: begin
          if (!annul_i) result_o <= zero_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: an arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_div;
  logic        clk, rst, start_i, annul_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [31:0] result_o;
  logic        ready_o, stallreq_o;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  div dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: RISC-V semantics via 64-bit integer division.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, qq, rr;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    return op[1] ? rr[31:0] : qq[31:0];
  endfunction

  // Model: cycles remaining until the ready cycle (0 = idle).
  int          m_left = 0;
  bit          m_zero = 1'b0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] exp_result = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left     <= 0;
      exp_result <= 32'd0;
    end else if (m_left == 0) begin
      if (start_i && !annul_i) begin
        m_zero <= (opdata2_i == 32'd0);
        m_left <= (opdata2_i == 32'd0) ? 2 : 33;
        m_pend <= ref_div(op_i, opdata1_i, opdata2_i);
      end
    end else if (m_left > 1 && annul_i) begin
      m_left <= 0;
    end else begin
      if (m_left == 2) exp_result <= m_pend;
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    logic exp_ready, exp_stall;
    exp_ready = rst && (m_left == 1);
    exp_stall = (m_left == 0 && start_i && !annul_i) || (m_left > 1 && (m_zero || !annul_i));
    chk("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
    chk("result_o", result_o, exp_result);
    chk("stallreq_o", {31'd0, stallreq_o}, {31'd0, exp_stall});
  end

  int last_ready_cyc;

  task automatic run_div(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input bit hold);
    int n, st;
    @(posedge clk); #1;
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    n = 0; st = 0;
    while (n < 60) begin
      @(negedge clk);
      if (stallreq_o) st++;
      if (ready_o) break;
      if (n == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      n++;
    end
    last_ready_cyc = cyc;
    chk({nm, " result"}, result_o, exp);
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " stall cycles"}, st, exp_lat);
    if (!hold) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, n;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 2'd0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result_o", result_o, 32'd0);
    chk("reset ready_o", {31'd0, ready_o}, 32'd0);
    chk("reset stallreq_o", {31'd0, stallreq_o}, 32'd0);
    rst = 1'b1;

    run_div("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_div("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_div("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_div("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_div("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run_div("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
    run_div("DIV 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_div("REMU x/0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, 1'b0);
    run_div("REM -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2, 1'b0);
    run_div("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    run_div("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    run_div("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);
    run_div("DIVU 1000/33", 2'b01, 32'd1000, 32'd33, 32'd30, 33, 1'b0);

    // Annul mid-divide: no strobe, result keeps the previous value (30).
    @(posedge clk); #1;
    op_i = 2'b01; opdata1_i = 32'd1000; opdata2_i = 32'd10; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) n++;
    end
    chk("annul no ready", n, 0);
    chk("annul result kept", result_o, 32'd30);
    run_div("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    // Reset mid-divide clears outputs asynchronously.
    @(posedge clk); #1;
    op_i = 2'b00; opdata1_i = 32'd100; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    start_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("async rst result_o", result_o, 32'd0);
    chk("async rst ready_o", {31'd0, ready_o}, 32'd0);
    chk("async rst stallreq_o", {31'd0, stallreq_o}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    run_div("DIV 20/4", 2'b00, 32'd20, 32'd4, 32'd5, 33, 1'b0);

    // Back-to-back with start_i held.
    run_div("b2b first", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    c1 = last_ready_cyc;
    run_div("b2b second", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    chk("b2b ready spacing", last_ready_cyc - c1, 34);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
